// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Takes the UART receiver's byte stream and assembles host command frames
//   of the form SOF, CMD, LEN, payload[LEN], checksum. The checksum is the
//   8-bit wrap-around sum of CMD, LEN and the payload bytes. Each good frame
//   is presented as one parallel command word with a valid/ready handshake.
//
//   Optional build macro: UART_CMD_TIMEOUT_EN
//     When defined, a frame in progress is aborted with o_Frame_Err if no byte
//     arrives for TIMEOUT_CLKS cycles. Without it, a stalled frame waits
//     indefinitely.
//
// Ports
//   i_Clock      system clock
//   i_Reset      synchronous reset, active-high
//   i_Rx_DV      one-cycle strobe, i_Rx_Byte valid
//   i_Rx_Byte    received byte
//   o_Cmd_Valid  command available (held until i_Cmd_Ready)
//   i_Cmd_Ready  consumer accepts command
//   o_Cmd        command opcode
//   o_Len        payload length
//   o_Payload    payload, byte k at [8k+7:8k], unused bytes zero
//   o_Frame_Err  one-cycle pulse: frame aborted (bad length/checksum/timeout)
//   o_Overrun    one-cycle pulse: byte dropped while a command is held
module uart_cmd_parser #(
  parameter int unsigned  MAX_LEN      = 4,
  parameter logic [7:0]   SOF_BYTE     = 8'hAA,
  parameter logic [15:0]  TIMEOUT_CLKS = 16'd50000
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Rx_DV,
  input  logic [7:0]             i_Rx_Byte,
  output logic                   o_Cmd_Valid,
  input  logic                   i_Cmd_Ready,
  output logic [7:0]             o_Cmd,
  output logic [7:0]             o_Len,
  output logic [8*MAX_LEN-1:0]   o_Payload,
  output logic                   o_Frame_Err,
  output logic                   o_Overrun
);

  // Byte index must reach MAX_LEN-1 for MAX_LEN up to 16.
  localparam int unsigned IDX_W     = 5;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  // Elaboration-time sanity checks on the configuration.
  if (MAX_LEN < 1 || MAX_LEN > 16) begin : g_bad_max_len
    $error("uart_cmd_parser: MAX_LEN must be in 1..16");
  end
  if (TIMEOUT_CLKS == 16'd0) begin : g_bad_timeout
    $error("uart_cmd_parser: TIMEOUT_CLKS must be non-zero");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } state_t;

  state_t               state;
  logic [7:0]           sum;
  logic [IDX_W-1:0]     idx;
  // Frame under assembly; copied to the outputs only once the checksum
  // matches, so a held or previously accepted command is never disturbed
  // by a frame that later fails.
  logic [7:0]           cmd_q;
  logic [7:0]           len_q;
  logic [8*MAX_LEN-1:0] pay_q;

`ifdef UART_CMD_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        in_frame;
  logic        timeout_hit;

  always_comb begin
    in_frame    = (state == ST_CMD) || (state == ST_LEN) ||
                  (state == ST_PAYLOAD) || (state == ST_CHECK);
    // Fires on the edge where the count reaches TIMEOUT_CLKS; a byte on
    // that same edge wins and the frame carries on.
    timeout_hit = in_frame && !i_Rx_DV && (tmo_cnt == TIMEOUT_CLKS - 16'd1);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Rx_DV || !in_frame) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      sum         <= '0;
      idx         <= '0;
      cmd_q       <= '0;
      len_q       <= '0;
      pay_q       <= '0;
      o_Cmd_Valid <= 1'b0;
      o_Cmd       <= '0;
      o_Len       <= '0;
      o_Payload   <= '0;
      o_Frame_Err <= 1'b0;
      o_Overrun   <= 1'b0;
    end else begin
      o_Frame_Err <= 1'b0;
      o_Overrun   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_Rx_DV && i_Rx_Byte == SOF_BYTE) begin
            state <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (i_Rx_DV) begin
            cmd_q <= i_Rx_Byte;
            sum   <= i_Rx_Byte;
            state <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (i_Rx_DV) begin
            if (i_Rx_Byte > MAX_LEN_B) begin
              o_Frame_Err <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              len_q <= i_Rx_Byte;
              sum   <= sum + i_Rx_Byte;
              idx   <= '0;
              pay_q <= '0;
              state <= (i_Rx_Byte == 8'd0) ? ST_CHECK : ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (i_Rx_DV) begin
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
              if (idx == IDX_W'(k)) begin
                pay_q[8*k +: 8] <= i_Rx_Byte;
              end
            end
            sum <= sum + i_Rx_Byte;
            idx <= idx + 1'b1;
            if (({3'b000, idx} + 8'd1) == len_q) begin
              state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (i_Rx_DV) begin
            if (i_Rx_Byte == sum) begin
              o_Cmd_Valid <= 1'b1;
              o_Cmd       <= cmd_q;
              o_Len       <= len_q;
              o_Payload   <= pay_q;
              state       <= ST_HOLD;
            end else begin
              o_Frame_Err <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end

        ST_HOLD: begin
          // Bytes here are lost, including on the handshake cycle itself.
          if (i_Rx_DV) begin
            o_Overrun <= 1'b1;
          end
          if (i_Cmd_Ready) begin
            o_Cmd_Valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

`ifdef UART_CMD_TIMEOUT_EN
      if (timeout_hit) begin
        o_Frame_Err <= 1'b1;
        state       <= ST_IDLE;
      end
`endif
    end
  end

endmodule
